// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issues one request at a time to a variable-latency ALU and buffers its
//   result for a writeback consumer.
//   IDLE accepts a request. EXEC holds the operator and operands stable until
//   the ALU reports ready and the writeback slot is free.
//
// Ports
//   core_clk, rst_n          clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_operator_i           7-bit ALU opcode
//   req_operand_a_i/_b_i     32-bit operands
//   alu_enable_o             high while EXEC
//   alu_operator_o           registered opcode to ALU
//   alu_operand_a_o/_b_o     registered operands to ALU
//   alu_ex_ready_o           ALU may retire (EXEC and writeback slot free)
//   alu_result_i             ALU result
//   alu_ready_i              ALU result available
//   wb_valid_o/wb_ready_i    writeback handshake
//   wb_result_o              writeback result
//   last_latency_o           EXEC cycles of last completed op, saturating at 63
module alu_issue_ctrl (
  input  logic        core_clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  req_operator_i,
  input  logic [31:0] req_operand_a_i,
  input  logic [31:0] req_operand_b_i,
  output logic        alu_enable_o,
  output logic [6:0]  alu_operator_o,
  output logic [31:0] alu_operand_a_o,
  output logic [31:0] alu_operand_b_o,
  output logic        alu_ex_ready_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_ready_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_result_o,
  input  logic        wb_ready_i,
  output logic [5:0]  last_latency_o
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic [5:0] cnt_q;
  logic       accept;
  logic       complete;

  assign req_ready_o    = (state_q == IDLE);
  assign alu_enable_o   = (state_q == EXEC);
  assign alu_ex_ready_o = alu_enable_o && (!wb_valid_o || wb_ready_i);
  assign accept         = req_valid_i && req_ready_o;
  assign complete       = alu_enable_o && alu_ready_i && alu_ex_ready_o;

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)   state_d = EXEC;
      EXEC: if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand registers load only on accept, so they stay frozen for all of EXEC.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_operator_o  <= '0;
      alu_operand_a_o <= '0;
      alu_operand_b_o <= '0;
      cnt_q           <= '0;
    end else if (accept) begin
      alu_operator_o  <= req_operator_i;
      alu_operand_a_o <= req_operand_a_i;
      alu_operand_b_o <= req_operand_b_i;
      cnt_q           <= 6'd1;
    end else if (alu_enable_o && !complete && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

  // A completion while the consumer drains the old result refills the slot
  // on the same edge, so wb_valid_o stays high.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o     <= 1'b0;
      wb_result_o    <= '0;
      last_latency_o <= '0;
    end else if (complete) begin
      wb_valid_o     <= 1'b1;
      wb_result_o    <= alu_result_i;
      last_latency_o <= cnt_q;
    end else if (wb_valid_o && wb_ready_i) begin
      wb_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        core_clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [6:0]  req_operator_i;
  logic [31:0] req_operand_a_i;
  logic [31:0] req_operand_b_i;
  logic        alu_enable_o;
  logic [6:0]  alu_operator_o;
  logic [31:0] alu_operand_a_o;
  logic [31:0] alu_operand_b_o;
  logic        alu_ex_ready_o;
  logic [31:0] alu_result_i;
  logic        alu_ready_i;
  logic        wb_valid_o;
  logic [31:0] wb_result_o;
  logic        wb_ready_i;
  logic [5:0]  last_latency_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [6:0] OP_ADD  = 7'b0011000;
  localparam logic [6:0] OP_DIVU = 7'b0110000;

  alu_issue_ctrl dut (
    .core_clk        (core_clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_operator_i  (req_operator_i),
    .req_operand_a_i (req_operand_a_i),
    .req_operand_b_i (req_operand_b_i),
    .alu_enable_o    (alu_enable_o),
    .alu_operator_o  (alu_operator_o),
    .alu_operand_a_o (alu_operand_a_o),
    .alu_operand_b_o (alu_operand_b_o),
    .alu_ex_ready_o  (alu_ex_ready_o),
    .alu_result_i    (alu_result_i),
    .alu_ready_i     (alu_ready_i),
    .wb_valid_o      (wb_valid_o),
    .wb_result_o     (wb_result_o),
    .wb_ready_i      (wb_ready_i),
    .last_latency_o  (last_latency_o)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 1'b0; req_operator_i = '0;
    req_operand_a_i = '0; req_operand_b_i = '0;
    alu_result_i = '0; alu_ready_i = 1'b0; wb_ready_i = 1'b1;
    #2;
    checks++; if (alu_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", alu_enable_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid_o); end
    checks++; if (wb_result_o !== 32'd0) begin errors++; $display("FAIL reset_wb_result got=%0d exp=0", wb_result_o); end
    checks++; if (last_latency_o !== 6'd0) begin errors++; $display("FAIL reset_latency got=%0d exp=0", last_latency_o); end
    checks++; if ({alu_operator_o, alu_operand_a_o, alu_operand_b_o} !== 71'd0) begin
      errors++; $display("FAIL reset_operands got=%h/%h/%h exp=0", alu_operator_o, alu_operand_a_o, alu_operand_b_o);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    req_valid_i = 1'b1; req_operator_i = OP_ADD; req_operand_a_i = 32'd5; req_operand_b_i = 32'd7;
    alu_ready_i = 1'b1; alu_result_i = 32'd12; wb_ready_i = 1'b1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL add_req_ready got=%b exp=1", req_ready_o); end
    tick();
    req_valid_i = 1'b0;
    checks++; if (alu_enable_o !== 1'b1) begin errors++; $display("FAIL add_enable got=%b exp=1", alu_enable_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL add_req_busy got=%b exp=0", req_ready_o); end
    checks++; if (alu_operator_o !== OP_ADD) begin errors++; $display("FAIL add_operator got=%b exp=%b", alu_operator_o, OP_ADD); end
    checks++; if (alu_operand_a_o !== 32'd5 || alu_operand_b_o !== 32'd7) begin
      errors++; $display("FAIL add_operands got=%0d,%0d exp=5,7", alu_operand_a_o, alu_operand_b_o);
    end
    checks++; if (alu_ex_ready_o !== 1'b1) begin errors++; $display("FAIL add_ex_ready got=%b exp=1", alu_ex_ready_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL add_wb_early got=%b exp=0", wb_valid_o); end
    tick();
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'd12) begin
      errors++; $display("FAIL add_result got=%b/%0d exp=1/12", wb_valid_o, wb_result_o);
    end
    checks++; if (last_latency_o !== 6'd1) begin errors++; $display("FAIL add_latency got=%0d exp=1", last_latency_o); end
    checks++; if (alu_enable_o !== 1'b0) begin errors++; $display("FAIL add_enable_drop got=%b exp=0", alu_enable_o); end
    tick();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL add_wb_consumed got=%b exp=0", wb_valid_o); end
  endtask

  task automatic test_divu();
    req_valid_i = 1'b1; req_operator_i = OP_DIVU; req_operand_a_i = 32'd100; req_operand_b_i = 32'd7;
    alu_ready_i = 1'b0; alu_result_i = 32'd14; wb_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0; req_operand_a_i = 32'hdead; req_operand_b_i = 32'hbeef;
    for (int i = 1; i <= 33; i++) begin
      checks++;
      if (alu_enable_o !== 1'b1 || alu_operator_o !== OP_DIVU || alu_operand_a_o !== 32'd100
          || alu_operand_b_o !== 32'd7 || wb_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL divu_hold cycle=%0d got=en%b op%b a%0d b%0d wb%b exp=en1 op%b a100 b7 wb0",
                 i, alu_enable_o, alu_operator_o, alu_operand_a_o, alu_operand_b_o, wb_valid_o, OP_DIVU);
      end
      tick();
    end
    alu_ready_i = 1'b1;
    checks++; if (alu_operand_a_o !== 32'd100) begin errors++; $display("FAIL divu_hold34 got=%0d exp=100", alu_operand_a_o); end
    tick();
    alu_ready_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'd14) begin
      errors++; $display("FAIL divu_result got=%b/%0d exp=1/14", wb_valid_o, wb_result_o);
    end
    checks++; if (last_latency_o !== 6'd34) begin errors++; $display("FAIL divu_latency got=%0d exp=34", last_latency_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    wb_ready_i = 1'b0; alu_ready_i = 1'b1; alu_result_i = 32'd3;
    req_valid_i = 1'b1; req_operator_i = OP_ADD; req_operand_a_i = 32'd1; req_operand_b_i = 32'd2;
    tick();
    req_valid_i = 1'b0;
    tick();
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'd3) begin
      errors++; $display("FAIL bp_first got=%b/%0d exp=1/3", wb_valid_o, wb_result_o);
    end
    req_valid_i = 1'b1; req_operand_a_i = 32'd10; req_operand_b_i = 32'd20; alu_result_i = 32'd30;
    tick();
    req_valid_i = 1'b0;
    checks++; if (alu_enable_o !== 1'b1 || alu_ex_ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_stall got=en%b exr%b exp=en1 exr0", alu_enable_o, alu_ex_ready_o);
    end
    tick();
    checks++; if (alu_enable_o !== 1'b1 || req_ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_stay_exec got=en%b rdy%b exp=en1 rdy0", alu_enable_o, req_ready_o);
    end
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'd3) begin
      errors++; $display("FAIL bp_hold got=%b/%0d exp=1/3", wb_valid_o, wb_result_o);
    end
    wb_ready_i = 1'b1;
    #1;
    checks++; if (alu_ex_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ex_ready got=%b exp=1", alu_ex_ready_o); end
    tick();
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'd30) begin
      errors++; $display("FAIL bp_swap got=%b/%0d exp=1/30", wb_valid_o, wb_result_o);
    end
    checks++; if (last_latency_o !== 6'd2) begin errors++; $display("FAIL bp_latency got=%0d exp=2", last_latency_o); end
    tick();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", wb_valid_o); end
  endtask

  task automatic test_hold_req();
    int unsigned pulses = 0;
    wb_ready_i = 1'b1; alu_ready_i = 1'b0; alu_result_i = 32'd3;
    req_valid_i = 1'b1; req_operator_i = OP_ADD; req_operand_a_i = 32'd1; req_operand_b_i = 32'd2;
    tick();
    for (int i = 0; i < 5; i++) begin
      req_operand_a_i = 32'd50 + i; req_operand_b_i = 32'd90 + i;
      checks++;
      if (req_ready_o !== 1'b0 || alu_operand_a_o !== 32'd1 || alu_operand_b_o !== 32'd2) begin
        errors++;
        $display("FAIL hold_req cycle=%0d got=rdy%b a%0d b%0d exp=rdy0 a1 b2", i, req_ready_o, alu_operand_a_o, alu_operand_b_o);
      end
      tick();
    end
    alu_ready_i = 1'b1; req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wb_valid_o === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL hold_one_result got=%0d exp=1", pulses); end
    checks++; if (wb_result_o !== 32'd3) begin errors++; $display("FAIL hold_result got=%0d exp=3", wb_result_o); end
  endtask

  task automatic test_reset_exec();
    wb_ready_i = 1'b1; alu_ready_i = 1'b0; alu_result_i = 32'd99;
    req_valid_i = 1'b1; req_operator_i = OP_DIVU; req_operand_a_i = 32'd500; req_operand_b_i = 32'd5;
    tick();
    req_valid_i = 1'b0;
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (alu_enable_o !== 1'b0 || alu_operand_a_o !== 32'd0) begin
      errors++; $display("FAIL rst_async got=en%b a%0d exp=en0 a0", alu_enable_o, alu_operand_a_o);
    end
    tick();
    checks++; if (wb_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_no_wb got=wb%b rdy%b exp=wb0 rdy1", wb_valid_o, req_ready_o);
    end
    rst_n = 1'b1;
    req_valid_i = 1'b1; req_operator_i = OP_ADD; req_operand_a_i = 32'd1; req_operand_b_i = 32'd1;
    alu_ready_i = 1'b1; alu_result_i = 32'd2;
    tick();
    req_valid_i = 1'b0;
    checks++; if (alu_enable_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_accept got=en%b wb%b exp=en1 wb0", alu_enable_o, wb_valid_o);
    end
    tick();
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'd2) begin
      errors++; $display("FAIL rst_add got=%b/%0d exp=1/2", wb_valid_o, wb_result_o);
    end
    tick();
  endtask

  task automatic test_saturation();
    wb_ready_i = 1'b1; alu_ready_i = 1'b0; alu_result_i = 32'd77;
    req_valid_i = 1'b1; req_operator_i = OP_DIVU; req_operand_a_i = 32'd9; req_operand_b_i = 32'd3;
    tick();
    req_valid_i = 1'b0;
    repeat (69) tick();
    checks++; if (wb_valid_o !== 1'b0 || alu_enable_o !== 1'b1) begin
      errors++; $display("FAIL sat_stall got=wb%b en%b exp=wb0 en1", wb_valid_o, alu_enable_o);
    end
    alu_ready_i = 1'b1;
    tick();
    alu_ready_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1 || wb_result_o !== 32'd77) begin
      errors++; $display("FAIL sat_result got=%b/%0d exp=1/77", wb_valid_o, wb_result_o);
    end
    checks++; if (last_latency_o !== 6'd63) begin errors++; $display("FAIL sat_latency got=%0d exp=63", last_latency_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_divu();
    test_back_to_back();
    test_hold_req();
    test_reset_exec();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
